// File: rtl/gen_next_block_queue_if.sv
// Purpose : bundles the next-piece generator's request/enable inputs, head-piece bus and preview pane.
// Latency : none (wires only).
// Backpress: req_i is honoured only while vld_o=1; en_i gates LFSR stepping.
// Ports (slave = generator side):
//   en_i, req_i                          in   LFSR step enable, pop head
//   vld_o, b_data, b_color, b_rotation   out  registered head piece
//   b_x, b_y                             out  spawn position
//   preview_id_o, preview_vld_o          out  ids/valids of the pieces behind the head
interface gen_next_block_queue_if #(
    parameter int QUEUE_DEPTH         = 3,
    parameter int TETRIS_COLORS_WIDTH = 3,
    parameter int FIELD_COL_CNT_WIDTH = 4,
    parameter int FIELD_ROW_CNT_WIDTH = 5
);
    logic                                  en_i;
    logic                                  req_i;
    logic                                  vld_o;
    logic [3:0][0:3][0:3]                  b_data;
    logic [TETRIS_COLORS_WIDTH-1:0]        b_color;
    logic [1:0]                            b_rotation;
    logic signed [FIELD_COL_CNT_WIDTH:0]   b_x;
    logic signed [FIELD_ROW_CNT_WIDTH:0]   b_y;
    logic [QUEUE_DEPTH-1:0][2:0]           preview_id_o;
    logic [QUEUE_DEPTH-1:0]                preview_vld_o;

    // Game control FSM side.
    modport master (
        output en_i, req_i,
        input  vld_o, b_data, b_color, b_rotation, b_x, b_y, preview_id_o, preview_vld_o
    );

    // Generator side.
    modport slave (
        input  en_i, req_i,
        output vld_o, b_data, b_color, b_rotation, b_x, b_y, preview_id_o, preview_vld_o
    );
endinterface

// File: rtl/gen_next_block_queue.sv
// Purpose : tetromino generator (PRBS15 draw, optional 7-bag) feeding a QUEUE_DEPTH+1 entry shift queue.
// Latency : first draw lands in slot 0 one cycle after reset release, head registered one cycle later.
// Backpress: req_i pops only when vld_o=1; a freed slot is refilled in the same cycle as the pop.
// Ports: clk_i, rst_n_i (async active-low); bus (gen_next_block_queue_if.slave): en_i, req_i in;
//        vld_o, b_data, b_color, b_rotation, b_x, b_y, preview_id_o, preview_vld_o out.
// Build option: define GEN_NEXT_BLOCK_BAG_EN to constrain draws to a 7-bag.
module gen_next_block_queue #(
    parameter int          QUEUE_DEPTH         = 3,
    parameter logic [14:0] LFSR_SEED           = 15'd1,
    parameter int          SPAWN_X             = 4,
    parameter int          SPAWN_Y             = 0,
    parameter int          TETRIS_COLORS_WIDTH = 3,
    parameter int          FIELD_COL_CNT_WIDTH = 4,
    parameter int          FIELD_ROW_CNT_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    gen_next_block_queue_if.slave bus
);
    localparam int SLOTS = QUEUE_DEPTH + 1;
    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int TCW   = TETRIS_COLORS_WIDTH;
    localparam int X_W   = FIELD_COL_CNT_WIDTH + 1;
    localparam int Y_W   = FIELD_ROW_CNT_WIDTH + 1;
    // An all-zero PRBS state would lock up, so fall back to 1.
    localparam logic [14:0] SEED = (LFSR_SEED == 15'd0) ? 15'd1 : LFSR_SEED;

    typedef struct packed {
        logic [2:0] id;
        logic [1:0] rot;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Four rotations packed {r3,r2,r1,r0}; each rotation is {row0..row3}, MSB of a row = column 0.
    function automatic logic [3:0][0:3][0:3] shape_bits(input logic [2:0] id);
        case (id)
            3'd0:    return 64'h4444_00F0_2222_0F00;  // I
            3'd1:    return 64'h44C0_0E20_6440_8E00;  // J
            3'd2:    return 64'hC440_0E80_4460_2E00;  // L
            3'd3:    return 64'h6600_6600_6600_6600;  // O
            3'd4:    return 64'h8C40_06C0_4620_6C00;  // S
            3'd5:    return 64'h4C40_0E40_4640_4E00;  // T
            3'd6:    return 64'h4C80_0C60_2640_C600;  // Z
            default: return 64'h0;
        endcase
    endfunction

    logic [14:0]               lfsr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_pop;
    entry_t [SLOTS-1:0]        slot_q;
    entry_t [SLOTS-1:0]        shifted;
    entry_t [SLOTS-1:0]        slot_d;
    logic                      pop;
    logic                      fill;
    logic [2:0]                cand;
    logic [2:0]                draw_id;
    logic                      vld_q;
    logic [3:0][0:3][0:3]      data_q;
    logic [TCW-1:0]            color_q;
    logic [1:0]                rot_q;

    assign cand = 3'(lfsr_q[7:0] % 8'd7);

`ifdef GEN_NEXT_BLOCK_BAG_EN
    logic [6:0] mask_q;
    logic [6:0] mask_d;
    logic [6:0] mask_set;
    logic [3:0] probe;
    logic       found;

    // First id not yet used in this bag, scanning upward from the LFSR candidate with wrap at 7.
    always_comb begin
        draw_id  = cand;
        found    = 1'b0;
        probe    = '0;
        for (int k = 0; k < 7; k++) begin
            probe = 4'(cand) + 4'(k);
            if (probe >= 4'd7) probe = probe - 4'd7;
            if (!found && !mask_q[probe[2:0]]) begin
                draw_id = probe[2:0];
                found   = 1'b1;
            end
        end
        mask_set = mask_q | (7'b1 << draw_id);
        mask_d   = mask_q;
        if (fill) mask_d = (mask_set == 7'h7F) ? 7'h00 : mask_set;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) mask_q <= '0;
        else          mask_q <= mask_d;
    end
`else
    assign draw_id = cand;
`endif

    always_comb begin
        pop     = bus.req_i & vld_q;
        cnt_pop = cnt_q - CNT_W'(pop);
        fill    = cnt_pop < CNT_W'(SLOTS);
        // Pop moves every slot down one; the top slot receives zero.
        shifted = pop ? (slot_q >> ENTRY_W) : slot_q;
        slot_d  = shifted;
        for (int i = 0; i < SLOTS; i++) begin
            if (fill && (cnt_pop == CNT_W'(i))) begin
                slot_d[i].id  = draw_id;
                slot_d[i].rot = lfsr_q[9:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            slot_q  <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            color_q <= '0;
            rot_q   <= '0;
        end else begin
            if (bus.en_i) lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
            cnt_q   <= cnt_pop + CNT_W'(fill);
            slot_q  <= slot_d;
            // Head tracks slot 0 after the pop but before the fill, so a draw into an
            // empty queue becomes visible one cycle later and vld_o never exceeds count.
            vld_q   <= (cnt_pop != '0);
            data_q  <= shape_bits(shifted[0].id);
            color_q <= TCW'(shifted[0].id) + TCW'(1);
            rot_q   <= shifted[0].rot;
        end
    end

    always_comb begin
        bus.preview_id_o  = '0;
        bus.preview_vld_o = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            bus.preview_id_o[i]  = slot_q[i+1].id;
            bus.preview_vld_o[i] = cnt_q > CNT_W'(i + 1);
        end
    end

    assign bus.vld_o      = vld_q;
    assign bus.b_data     = data_q;
    assign bus.b_color    = color_q;
    assign bus.b_rotation = rot_q;
    assign bus.b_x        = X_W'(SPAWN_X);
    assign bus.b_y        = Y_W'(SPAWN_Y);
endmodule
